// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - job sequencer issuing core instruction words for kernel load, execute, drain and normalization
//
// Purpose: walks one full job (kernel load, optional idle gap, query execution,
// output-FIFO drain into psum memory, optional accumulate/divide normalization)
// and presents one registered instruction word per cycle.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears all state and outputs
//   start        job request, honoured only in IDLE
//   norm_en      normalization enable, latched together with start
//   ofifo_valid  output FIFO holds at least one complete row
//   inst[16:0]   {ofifo_rd, qkmem_add[3:0], pmem_add[3:0], execute, kload,
//                 qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr}
//   acc          SFP accumulate strobe
//   div          SFP divide strobe
//   wr_norm      selects SFP output as psum write data
//   busy         job in progress (not IDLE, not DONE)
//   done         one-cycle job-complete pulse
module core_ctrl #(
    parameter int col = 8,
    parameter int nq  = 8,
    parameter int gap = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        norm_en,
    input  logic        ofifo_valid,
    output logic [16:0] inst,
    output logic        acc,
    output logic        div,
    output logic        wr_norm,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE, S_KLOAD, S_KWAIT, S_EXEC, S_DRAIN, S_NACC, S_NDIV, S_DONE
    } state_t;

    // Drain phases: wait for FIFO, read FIFO, write psum row.
    // Divide phases reuse the same encoding: read, divide, write.
    localparam logic [1:0] PH_0 = 2'd0;
    localparam logic [1:0] PH_1 = 2'd1;
    localparam logic [1:0] PH_2 = 2'd2;

    localparam logic [4:0] COL_C    = 5'(col);
    localparam logic [4:0] NQ_C     = 5'(nq);
    localparam logic [3:0] NQ_LAST  = 4'(nq - 1);
    localparam logic [4:0] GAP_LAST = 5'((gap > 0) ? gap - 1 : 0);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  row_q, row_d;
    logic [1:0]  phase_q, phase_d;
    logic        norm_q, norm_d;

    logic [16:0] inst_q, inst_d;
    logic        acc_q, acc_d;
    logic        div_q, div_d;
    logic        wr_norm_q, wr_norm_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            phase_q   <= PH_0;
            norm_q    <= 1'b0;
            inst_q    <= '0;
            acc_q     <= 1'b0;
            div_q     <= 1'b0;
            wr_norm_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            phase_q   <= phase_d;
            norm_q    <= norm_d;
            inst_q    <= inst_d;
            acc_q     <= acc_d;
            div_q     <= div_d;
            wr_norm_q <= wr_norm_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: state/cnt/row/phase describe the cycle being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        phase_d = phase_q;
        norm_d  = norm_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_KLOAD;
                    cnt_d   = '0;
                    norm_d  = norm_en;
                end
            end
            S_KLOAD: begin
                if (cnt_q == COL_C) begin
                    state_d = (gap == 0) ? S_EXEC : S_KWAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_KWAIT: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_EXEC: begin
                if (cnt_q == NQ_C) begin
                    state_d = S_DRAIN;
                    row_d   = '0;
                    phase_d = ofifo_valid ? PH_1 : PH_0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DRAIN: begin
                case (phase_q)
                    PH_0:    if (ofifo_valid) phase_d = PH_1;
                    PH_1:    phase_d = PH_2;
                    default: begin
                        if (row_q == NQ_LAST) begin
                            state_d = norm_q ? S_NACC : S_DONE;
                            cnt_d   = '0;
                            phase_d = PH_0;
                        end else begin
                            row_d   = row_q + 4'd1;
                            phase_d = ofifo_valid ? PH_1 : PH_0;
                        end
                    end
                endcase
            end
            S_NACC: begin
                if (cnt_q == NQ_C) begin
                    state_d = S_NDIV;
                    row_d   = '0;
                    phase_d = PH_0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_NDIV: begin
                case (phase_q)
                    PH_0:    phase_d = PH_1;
                    PH_1:    phase_d = PH_2;
                    default: begin
                        phase_d = PH_0;
                        if (row_q == NQ_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + 4'd1;
                        end
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                row_d   = '0;
                phase_d = PH_0;
            end
        endcase
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        inst_d    = '0;
        acc_d     = 1'b0;
        div_d     = 1'b0;
        wr_norm_d = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
        case (state_d)
            S_KLOAD: begin
                if (cnt_d < COL_C) begin
                    inst_d[3]     = 1'b1;
                    inst_d[15:12] = cnt_d[3:0];
                end
                // Kernel data arrives one cycle after its read.
                inst_d[6] = (cnt_d != 5'd0);
            end
            S_EXEC: begin
                if (cnt_d < NQ_C) begin
                    inst_d[5]     = 1'b1;
                    inst_d[15:12] = cnt_d[3:0];
                end
                inst_d[7] = (cnt_d != 5'd0);
            end
            S_DRAIN: begin
                if (phase_d == PH_1) begin
                    inst_d[16] = 1'b1;
                end else if (phase_d == PH_2) begin
                    inst_d[0]    = 1'b1;
                    inst_d[11:8] = row_d;
                end
            end
            S_NACC: begin
                if (cnt_d < NQ_C) begin
                    inst_d[1]    = 1'b1;
                    inst_d[11:8] = cnt_d[3:0];
                end
                acc_d = (cnt_d != 5'd0);
            end
            S_NDIV: begin
                inst_d[11:8] = row_d;
                case (phase_d)
                    PH_0:    inst_d[1] = 1'b1;
                    PH_1:    div_d     = 1'b1;
                    default: begin
                        inst_d[0] = 1'b1;
                        wr_norm_d = 1'b1;
                    end
                endcase
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    assign inst    = inst_q;
    assign acc     = acc_q;
    assign div     = div_q;
    assign wr_norm = wr_norm_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - directed self-checking bench for core_ctrl
module tb_core_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic        norm_en;
    logic        ofifo_valid;
    logic [16:0] inst_a, inst_b;
    logic        acc_a, div_a, wr_norm_a, busy_a, done_a;
    logic        acc_b, div_b, wr_norm_b, busy_b, done_b;
    logic [21:0] obs_a, obs_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    core_ctrl #(.col(8), .nq(8), .gap(4)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .norm_en(norm_en),
        .ofifo_valid(ofifo_valid), .inst(inst_a), .acc(acc_a), .div(div_a),
        .wr_norm(wr_norm_a), .busy(busy_a), .done(done_a)
    );

    core_ctrl #(.col(16), .nq(16), .gap(0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .norm_en(norm_en),
        .ofifo_valid(ofifo_valid), .inst(inst_b), .acc(acc_b), .div(div_b),
        .wr_norm(wr_norm_b), .busy(busy_b), .done(done_b)
    );

    assign obs_a = {inst_a, acc_a, div_a, wr_norm_a, busy_a, done_a};
    assign obs_b = {inst_b, acc_b, div_b, wr_norm_b, busy_b, done_b};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected {inst, acc, div, wr_norm, busy, done} at cycle t of a job whose
    // start was sampled at the end of cycle 0, with ofifo_valid held high.
    function automatic logic [21:0] exp_vec(input int t, input int c_, input int n_,
                                            input int g_, input bit nm);
        logic [16:0] i;
        logic a, d, w, b, dn;
        int kw, ex, dr, en, nd, dt, k, ph;
        i = '0; a = 0; d = 0; w = 0;
        kw = 2 + c_;
        ex = kw + g_;
        dr = ex + n_ + 1;
        en = dr + 2 * n_;
        nd = en + n_ + 1;
        dt = nm ? nd + 3 * n_ : en;
        if (t >= 1 && t < kw) begin
            k = t - 1;
            if (k < c_) begin i[3] = 1'b1; i[15:12] = k[3:0]; end
            if (k >= 1) i[6] = 1'b1;
        end else if (t >= ex && t < dr) begin
            k = t - ex;
            if (k < n_) begin i[5] = 1'b1; i[15:12] = k[3:0]; end
            if (k >= 1) i[7] = 1'b1;
        end else if (t >= dr && t < en) begin
            k = (t - dr) / 2;
            if (((t - dr) % 2) == 0) i[16] = 1'b1;
            else begin i[0] = 1'b1; i[11:8] = k[3:0]; end
        end else if (nm && t >= en && t < nd) begin
            k = t - en;
            if (k < n_) begin i[1] = 1'b1; i[11:8] = k[3:0]; end
            a = (k >= 1);
        end else if (nm && t >= nd && t < dt) begin
            k = (t - nd) / 3;
            ph = (t - nd) % 3;
            i[11:8] = k[3:0];
            if (ph == 0) i[1] = 1'b1;
            else if (ph == 1) d = 1'b1;
            else begin i[0] = 1'b1; w = 1'b1; end
        end
        dn = (t == dt);
        b = (t >= 1) && (t < dt);
        return {i, a, d, w, b, dn};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Issues start in cycle 0 and checks every cycle 1..last_t.
    task automatic run_seq(input string nm, input bit use_b, input bit norm,
                           input int last_t, input bit hold);
        logic [21:0] e;
        step();
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        norm_en = norm;
        for (int t = 1; t <= last_t; t++) begin
            step();
            if (t == 1) begin
                norm_en = 1'b0;
                if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
            end
            if (use_b) begin
                e = exp_vec(t, 16, 16, 0, norm);
                chk($sformatf("%s c%0d", nm, t), {10'd0, obs_b}, {10'd0, e});
            end else begin
                e = exp_vec(t, 8, 8, 4, norm);
                chk($sformatf("%s c%0d", nm, t), {10'd0, obs_a}, {10'd0, e});
            end
        end
    endtask

    initial begin
        logic [21:0] e;
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        norm_en = 1'b0; ofifo_valid = 1'b1;
        step();
        step();
        chk("reset_a", {10'd0, obs_a}, 32'd0);
        chk("reset_b", {10'd0, obs_b}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("idle_a %0d", k), {10'd0, obs_a}, 32'd0);
        end

        // Basic job, no normalization: done at cycle 39, idle at 40.
        run_seq("job", 1'b0, 1'b0, 40, 1'b0);

        // Job with normalization: done at cycle 72.
        run_seq("norm", 1'b0, 1'b1, 73, 1'b0);

        // FIFO stall of 10 cycles while waiting for row 3.
        step();
        start_a = 1'b1;
        for (int t = 1; t <= 50; t++) begin
            step();
            if (t == 1) start_a = 1'b0;
            if (t < 29) e = exp_vec(t, 8, 8, 4, 1'b0);
            else if (t <= 38) e = {17'd0, 5'b00010};
            else e = exp_vec(t - 10, 8, 8, 4, 1'b0);
            chk($sformatf("stall c%0d", t), {10'd0, obs_a}, {10'd0, e});
            if (t == 28) ofifo_valid = 1'b0;
            if (t == 38) ofifo_valid = 1'b1;
        end
        chk("stall_rd", {15'd0, inst_a}, 32'd0);

        // Asynchronous reset during EXEC c=5 (cycle 19).
        run_seq("pre_rst", 1'b0, 1'b0, 19, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("async_inst", {15'd0, inst_a}, 32'd0);
        chk("async_busy", {31'd0, busy_a}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_idle", {10'd0, obs_a}, 32'd0);
        run_seq("after_rst", 1'b0, 1'b0, 40, 1'b0);

        // start held high: one job, one done, next job only after IDLE.
        run_seq("hold", 1'b0, 1'b0, 40, 1'b1);
        step();
        chk("hold_restart", {10'd0, obs_a}, {10'd0, 17'h00008, 5'b00010});
        start_a = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // col=16, nq=16, gap=0: full address range, no KWAIT.
        run_seq("wide", 1'b1, 1'b0, 68, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
